// File: rtl/i2s_frame_scheduler.sv
// I2S frame scheduler: divides clk into MCLK/SCLK/LRCK and fetches one stereo sample per frame.
// Outputs update on the edge that ends the fetch cycle (visible at div_cnt==0); sources are strobed, never stalled.
module i2s_frame_scheduler #(
  parameter int MCLK_BIT         = 1,
  parameter int SCLK_BIT         = 4,
  parameter int LRCK_BIT         = 9,
  parameter bit HOLD_ON_UNDERRUN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        src0_valid,
  input  logic [15:0] src0_left,
  input  logic [15:0] src0_right,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_left,
  input  logic [15:0] src1_right,
  output logic        src1_ready,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        mclk,
  output logic        lrck,
  output logic        sclk,
  output logic        frame_tick,
  output logic [15:0] underrun_cnt
);

  localparam int            DW       = LRCK_BIT + 1;
  localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DIV_LAST = {DW{1'b1}};
  localparam logic [DW-1:0] DIV_PRE  = {{(DW-1){1'b1}}, 1'b0};

  logic [DW-1:0]      div_cnt;
  logic               fetch;
  logic               take0, take1;
  logic               underrun;
  logic [15:0]        nxt_left, nxt_right;
  logic [15:0]        a_l, a_r, b_l, b_r;
  logic signed [16:0] sum_l, sum_r;

  assign mclk  = div_cnt[MCLK_BIT];
  assign sclk  = div_cnt[SCLK_BIT];
  assign lrck  = div_cnt[LRCK_BIT];
  assign fetch = (div_cnt == DIV_LAST);

  // Ready is only ever high in the fetch cycle, so ready & valid is the handshake.
  assign take0 = src0_ready & src0_valid;
  assign take1 = src1_ready & src1_valid;

  assign a_l   = take0 ? src0_left  : 16'd0;
  assign a_r   = take0 ? src0_right : 16'd0;
  assign b_l   = take1 ? src1_left  : 16'd0;
  assign b_r   = take1 ? src1_right : 16'd0;
  assign sum_l = $signed({a_l[15], a_l}) + $signed({b_l[15], b_l});
  assign sum_r = $signed({a_r[15], a_r}) + $signed({b_r[15], b_r});

  function automatic logic [15:0] clamp16(input logic signed [16:0] s);
    case (s[16:15])
      2'b01:   clamp16 = 16'h7FFF;
      2'b10:   clamp16 = 16'h8000;
      default: clamp16 = s[15:0];
    endcase
  endfunction

  always_comb begin
    nxt_left  = out_left;
    nxt_right = out_right;
    underrun  = 1'b0;
    case (mode)
      2'd0: begin
        if (take0) begin
          nxt_left  = src0_left;
          nxt_right = src0_right;
        end else begin
          underrun = 1'b1;
        end
      end
      2'd1: begin
        if (take1) begin
          nxt_left  = src1_left;
          nxt_right = src1_right;
        end else if (take0) begin
          nxt_left  = src0_left;
          nxt_right = src0_right;
        end else begin
          underrun = 1'b1;
        end
      end
      2'd2: begin
        if (take0 || take1) begin
          nxt_left  = clamp16(sum_l);
          nxt_right = clamp16(sum_r);
        end else begin
          underrun = 1'b1;
        end
      end
      default: begin
        nxt_left  = 16'd0;
        nxt_right = 16'd0;
      end
    endcase
    if (underrun && !HOLD_ON_UNDERRUN) begin
      nxt_left  = 16'd0;
      nxt_right = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      src0_ready   <= 1'b0;
      src1_ready   <= 1'b0;
      frame_tick   <= 1'b0;
      out_left     <= 16'd0;
      out_right    <= 16'd0;
      underrun_cnt <= 16'd0;
    end else begin
      div_cnt    <= div_cnt + DIV_ONE;
      src0_ready <= (div_cnt == DIV_PRE);
      src1_ready <= (div_cnt == DIV_PRE) && (mode != 2'd0);
      frame_tick <= fetch;
      if (fetch) begin
        out_left  <= nxt_left;
        out_right <= nxt_right;
        if (underrun && underrun_cnt != 16'hFFFF)
          underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler; a zero-output and a hold-on-underrun instance share stimulus.
module tb_i2s_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        src0_valid, src1_valid;
  logic [15:0] src0_left, src0_right, src1_left, src1_right;

  logic        src0_ready, src1_ready, mclk, lrck, sclk, frame_tick;
  logic [15:0] out_left, out_right, underrun_cnt;
  logic        h_src0_ready, h_src1_ready, h_mclk, h_lrck, h_sclk, h_frame_tick;
  logic [15:0] h_out_left, h_out_right, h_underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int ph    = 0;

  always #5 clk = ~clk;

  i2s_frame_scheduler dut (
    .clk(clk), .reset(reset), .mode(mode),
    .src0_valid(src0_valid), .src0_left(src0_left), .src0_right(src0_right), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_left(src1_left), .src1_right(src1_right), .src1_ready(src1_ready),
    .out_left(out_left), .out_right(out_right), .mclk(mclk), .lrck(lrck), .sclk(sclk),
    .frame_tick(frame_tick), .underrun_cnt(underrun_cnt)
  );

  i2s_frame_scheduler #(.HOLD_ON_UNDERRUN(1'b1)) dut_h (
    .clk(clk), .reset(reset), .mode(mode),
    .src0_valid(src0_valid), .src0_left(src0_left), .src0_right(src0_right), .src0_ready(h_src0_ready),
    .src1_valid(src1_valid), .src1_left(src1_left), .src1_right(src1_right), .src1_ready(h_src1_ready),
    .out_left(h_out_left), .out_right(h_out_right), .mclk(h_mclk), .lrck(h_lrck), .sclk(h_sclk),
    .frame_tick(h_frame_tick), .underrun_cnt(h_underrun_cnt)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ph = (ph + 1) % 1024;
    end
  endtask

  // Advances one full frame from ph 0 to the next ph 0 (the new frame_tick cycle).
  task automatic next_frame();
    step(1024);
  endtask

  task automatic test_reset();
    int e_mclk, e_sclk, e_lrck, e_rdy, e_tick;
    e_mclk = 0; e_sclk = 0; e_lrck = 0; e_rdy = 0; e_tick = 0;
    reset = 1'b1; mode = 2'd0;
    src0_valid = 1'b1; src0_left = 16'h1234; src0_right = 16'hABCD;
    src1_valid = 1'b1; src1_left = 16'h5555; src1_right = 16'h6666;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ph = 0;
    n_cmp++;
    if ({out_left, out_right, underrun_cnt} !== 48'd0 || {mclk, sclk, lrck, frame_tick, src0_ready, src1_ready} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_state: out=%h/%h ur=%h clks=%b%b%b tick=%b rdy=%b%b required all zero",
               out_left, out_right, underrun_cnt, mclk, sclk, lrck, frame_tick, src0_ready, src1_ready);
    end
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      ph = k % 1024;
      if (mclk !== k[1]) e_mclk++;
      if (sclk !== k[4]) e_sclk++;
      if (lrck !== k[9]) e_lrck++;
      if (src0_ready !== (k == 1023)) e_rdy++;
      if (frame_tick !== (k == 1024)) e_tick++;
    end
    n_cmp++; if (e_mclk !== 0) begin n_err++; $display("FAIL mclk_div: %0d bad cycles, required 0", e_mclk); end
    n_cmp++; if (e_sclk !== 0) begin n_err++; $display("FAIL sclk_div: %0d bad cycles, required 0", e_sclk); end
    n_cmp++; if (e_lrck !== 0) begin n_err++; $display("FAIL lrck_div: %0d bad cycles, required 0", e_lrck); end
    n_cmp++; if (e_rdy  !== 0) begin n_err++; $display("FAIL first_ready_1023: %0d bad cycles, required 0", e_rdy); end
    n_cmp++; if (e_tick !== 0) begin n_err++; $display("FAIL first_tick_1024: %0d bad cycles, required 0", e_tick); end
  endtask

  task automatic test_mode0();
    int e_out, e_s1, e_tick;
    e_out = 0; e_s1 = 0; e_tick = 0;
    for (int i = 0; i < 1024; i++) begin
      if (out_left !== 16'h1234 || out_right !== 16'hABCD) e_out++;
      if (src1_ready !== 1'b0) e_s1++;
      if (frame_tick !== (i == 0)) e_tick++;
      step(1);
    end
    n_cmp++; if (e_out !== 0) begin n_err++; $display("FAIL mode0_out_stable: %0d bad cycles, required 0", e_out); end
    n_cmp++; if (e_s1 !== 0) begin n_err++; $display("FAIL mode0_src1_ready: %0d bad cycles, required 0", e_s1); end
    n_cmp++; if (e_tick !== 0) begin n_err++; $display("FAIL mode0_tick_once: %0d bad cycles, required 0", e_tick); end
  endtask

  task automatic test_mode1();
    mode = 2'd1;
    src0_left = 16'd100; src0_right = 16'd7;
    src1_left = 16'hFFFB; src1_right = 16'd9;
    next_frame();
    n_cmp++;
    if (out_left !== 16'hFFFB || out_right !== 16'd9) begin
      n_err++; $display("FAIL mode1_src1_wins: out=%h/%h required fffb/0009", out_left, out_right);
    end
    src1_valid = 1'b0;
    next_frame();
    n_cmp++;
    if (out_left !== 16'd100 || out_right !== 16'd7 || underrun_cnt !== 16'd0) begin
      n_err++; $display("FAIL mode1_fallback: out=%h/%h ur=%0d required 0064/0007 ur=0", out_left, out_right, underrun_cnt);
    end
  endtask

  task automatic test_mix();
    mode = 2'd2;
    src0_valid = 1'b1; src0_left = 16'd30000; src0_right = 16'hB1E0;
    src1_valid = 1'b1; src1_left = 16'd10000; src1_right = 16'hB1E0;
    next_frame();
    n_cmp++;
    if (out_left !== 16'h7FFF || out_right !== 16'h8000) begin
      n_err++; $display("FAIL mix_saturate: out=%h/%h required 7fff/8000", out_left, out_right);
    end
    src0_left = 16'hFED4; src0_right = 16'd5;
    src1_left = 16'd200;  src1_right = 16'd6;
    next_frame();
    n_cmp++;
    if (out_left !== 16'hFF9C || out_right !== 16'd11) begin
      n_err++; $display("FAIL mix_plain_sum: out=%h/%h required ff9c/000b", out_left, out_right);
    end
    src1_valid = 1'b0;
    src0_left = 16'd1000; src0_right = 16'hFFFD;
    next_frame();
    n_cmp++;
    if (out_left !== 16'd1000 || out_right !== 16'hFFFD || underrun_cnt !== 16'd0) begin
      n_err++; $display("FAIL mix_single_src: out=%h/%h ur=%0d required 03e8/fffd ur=0", out_left, out_right, underrun_cnt);
    end
  endtask

  task automatic test_underrun();
    int e_zero, e_hold;
    e_zero = 0; e_hold = 0;
    mode = 2'd0; src0_valid = 1'b0; src1_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      next_frame();
      if (out_left !== 16'd0 || out_right !== 16'd0) e_zero++;
      if (h_out_left !== 16'd1000 || h_out_right !== 16'hFFFD) e_hold++;
    end
    n_cmp++; if (e_zero !== 0) begin n_err++; $display("FAIL underrun_zero: %0d bad frames, required 0", e_zero); end
    n_cmp++; if (e_hold !== 0) begin n_err++; $display("FAIL underrun_hold: %0d bad frames, last=%h/%h required 03e8/fffd", e_hold, h_out_left, h_out_right); end
    n_cmp++;
    if (underrun_cnt !== 16'd3 || h_underrun_cnt !== 16'd3) begin
      n_err++; $display("FAIL underrun_count: got %0d/%0d required 3/3", underrun_cnt, h_underrun_cnt);
    end
    mode = 2'd3;
    next_frame();
    n_cmp++;
    if (underrun_cnt !== 16'd3 || h_out_left !== 16'd0 || h_out_right !== 16'd0) begin
      n_err++; $display("FAIL mute_no_underrun: ur=%0d hold_out=%h/%h required 3 0000/0000", underrun_cnt, h_out_left, h_out_right);
    end
  endtask

  task automatic test_mode_change();
    int e_keep;
    e_keep = 0;
    mode = 2'd0;
    src0_valid = 1'b1; src0_left = 16'd11; src0_right = 16'd22;
    src1_valid = 1'b1; src1_left = 16'd33; src1_right = 16'd44;
    next_frame();
    step(300);
    mode = 2'd1;
    while (ph != 1023) begin
      if (out_left !== 16'd11 || out_right !== 16'd22) e_keep++;
      step(1);
    end
    n_cmp++; if (e_keep !== 0) begin n_err++; $display("FAIL midframe_mode_hold: %0d bad cycles, required 0", e_keep); end
    n_cmp++; if (src1_ready !== 1'b1) begin n_err++; $display("FAIL mode1_src1_ready: got %b required 1", src1_ready); end
    step(1);
    n_cmp++;
    if (out_left !== 16'd33 || out_right !== 16'd44 || frame_tick !== 1'b1) begin
      n_err++; $display("FAIL mode_change_applies: out=%0d/%0d tick=%b required 33/44 tick=1", out_left, out_right, frame_tick);
    end
  endtask

  task automatic test_mid_reset();
    mode = 2'd0; src1_valid = 1'b0;
    src0_valid = 1'b1; src0_left = 16'd55; src0_right = 16'd66;
    step(1023);
    n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL fetch_ready_before_reset: got %b required 1", src0_ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ph = 0;
    n_cmp++;
    if ({out_left, out_right, underrun_cnt} !== 48'd0 || {mclk, sclk, lrck, frame_tick, src0_ready, src1_ready} !== 6'd0 ||
        dut.div_cnt !== 10'd0) begin
      n_err++; $display("FAIL reset_in_fetch: out=%h/%h ur=%h tick=%b rdy=%b%b div=%0d required all zero",
                        out_left, out_right, underrun_cnt, frame_tick, src0_ready, src1_ready, dut.div_cnt);
    end
    step(1);
    n_cmp++; if (src0_ready !== 1'b0) begin n_err++; $display("FAIL no_ready_after_reset: got %b required 0", src0_ready); end
    step(1022);
    n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_rerelease: got %b required 1", src0_ready); end
    step(1);
    n_cmp++;
    if (out_left !== 16'd55 || out_right !== 16'd66 || frame_tick !== 1'b1) begin
      n_err++; $display("FAIL fetch_after_reset: out=%0d/%0d tick=%b required 55/66 tick=1", out_left, out_right, frame_tick);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mix();
    test_underrun();
    test_mode_change();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
